// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control FSM: states, opcodes, select encodings.
// The addi path exists only when CTRL_ADDI_EN is defined.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_JUMP   = 4'd10
`ifdef CTRL_ADDI_EN
      ,
      S_ADDI   = 4'd11,
      S_AWB    = 4'd12
`endif
   } state_t;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_4       = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // S_FETCH as the target doubles as the "unknown opcode" marker.
   function automatic state_t decode_target(input logic [5:0] op);
      decode_target = S_FETCH;
      case (op)
         OP_LW, OP_SW: decode_target = S_MEMADR;
         OP_RTYPE:     decode_target = S_EXEC;
         OP_BEQ:       decode_target = S_BEQ;
         OP_J:         decode_target = S_JUMP;
`ifdef CTRL_ADDI_EN
         OP_ADDI:      decode_target = S_ADDI;
`endif
         default:      decode_target = S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control decode for the multicycle FSM; combinational, zero latency.
// Fetch strobes and illegal_op are the only outputs that also depend on inputs.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   input  logic       op_illegal,
   output logic       PCWRITE,
   output logic       BRANCH,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       illegal_op
);

   always_comb begin
      PCWRITE    = 1'b0;
      BRANCH     = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_B;
      ALUOp      = ALUOP_ADD;
      PCSource   = PCSRC_ALU;
      illegal_op = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_4;
            // IR load and PC+4 commit only when the instruction word arrives
            IRWrite = mem_ready;
            PCWRITE = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB    = SRCB_SEXT_SH;
            illegal_op = op_illegal;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_SEXT;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_SUB;
            PCSource = PCSRC_ALUOUT;
            BRANCH   = 1'b1;
         end
         S_JUMP: begin
            PCWRITE  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
`ifdef CTRL_ADDI_EN
         S_ADDI: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_SEXT;
         end
         S_AWB: begin
            RegWrite = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main control FSM; 3-5 cycles per instruction, memory states stall on mem_ready.
// Define CTRL_ADDI_EN to add the addi path (S_ADDI, S_AWB).
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] Opcode,
   input  logic            mem_ready,
   output logic            PCWRITE,
   output logic            BRANCH,
   output logic            IorD,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            RegDst,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic [1:0]      PCSource,
   output logic            illegal_op
);

   state_t state;
   state_t dec_tgt;
   logic   op_illegal;
   logic   op_is_lw;

   assign dec_tgt    = decode_target(6'(Opcode));
   assign op_illegal = (dec_tgt == S_FETCH);
   assign op_is_lw   = (6'(Opcode) == OP_LW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_RST;
      end else begin
         case (state)
            S_RST:    state <= S_FETCH;
            S_FETCH:  if (mem_ready) state <= S_DECODE;
            S_DECODE: state <= dec_tgt;
            S_MEMADR: state <= op_is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state <= S_MEMWB;
            S_MEMWB:  state <= S_FETCH;
            S_MEMWR:  if (mem_ready) state <= S_FETCH;
            S_EXEC:   state <= S_RWB;
            S_RWB:    state <= S_FETCH;
            S_BEQ:    state <= S_FETCH;
            S_JUMP:   state <= S_FETCH;
`ifdef CTRL_ADDI_EN
            S_ADDI:   state <= S_AWB;
            S_AWB:    state <= S_FETCH;
`endif
            default:  state <= S_FETCH;
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .state      (state),
      .mem_ready  (mem_ready),
      .op_illegal (op_illegal),
      .PCWRITE    (PCWRITE),
      .BRANCH     (BRANCH),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .PCSource   (PCSource),
      .illegal_op (illegal_op)
   );

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle CPU.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath control line: PC write, branch enable, memory, IR, register file, ALU and PC-source selects.
- Stretches memory states with a ready handshake.
- Sits beside the datapath; its PCWRITE and BRANCH outputs feed the PC update logic, which ORs PCWRITE with BranchTaken&BRANCH.

## Interface
Parameters:
- OP_W, 6, opcode width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Opcode  in  OP_W  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes access this cycle
- PCWRITE  out  1  unconditional PC write
- BRANCH  out  1  conditional PC write enable (beq)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unknown opcode

## Operation
- Reset puts the FSM in S_RST; all outputs are 0 there. S_RST always advances to S_FETCH on the next clock.
- Outputs are Moore decodes of state, except where noted as gated by mem_ready.
- S_FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWRITE assert only in the cycle mem_ready=1; that cycle advances to S_DECODE. Otherwise hold.
- S_DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 100011 lw and 101011 sw -> S_MEMADR
  - 000000 R-type -> S_EXEC
  - 000100 beq -> S_BEQ
  - 000010 j -> S_JUMP
  - 001000 addi -> S_ADDI (CTRL_ADDI_EN only)
  - any other opcode -> S_FETCH with illegal_op=1 for that cycle
- S_MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to S_MEMWB.
- S_MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to S_FETCH.
- S_MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then goes to S_FETCH.
- S_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to S_RWB.
- S_RWB: RegWrite=1, RegDst=1, MemtoReg=0. Goes to S_FETCH.
- S_BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, BRANCH=1. Goes to S_FETCH.
- S_JUMP: PCWRITE=1, PCSource=10. Goes to S_FETCH.
- Opcode is sampled only in S_DECODE and S_MEMADR.
- mem_ready is ignored outside S_FETCH, S_MEMRD and S_MEMWR.
- PCWRITE and BRANCH are never both 1 in the same cycle.
- MemRead and MemWrite are never both 1 in the same cycle.

## Timing
- Cycles per instruction with zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle (mem_ready=0) in a memory state adds exactly 1 cycle.
- Reset asserted mid-instruction forces S_RST and all-zero outputs immediately (asynchronous).
- The first fetch begins 2 clocks after rst_n rises (S_RST, then S_FETCH).
- illegal_op is high exactly in the S_DECODE cycle; the next cycle is S_FETCH, and no register, memory or PC write occurs in between.

## Configuration
- CTRL_ADDI_EN defined: opcode 001000 decodes to S_ADDI, then S_AWB.
  - S_ADDI: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - S_AWB: RegWrite=1, RegDst=0, MemtoReg=0, then S_FETCH.
- CTRL_ADDI_EN undefined: 001000 is illegal (illegal_op pulse, back to S_FETCH), and S_ADDI/S_AWB do not exist.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state enumeration;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUSrcB, ALUOp and PCSource encodings.
- One sub-module, mc_ctrl_decode, holds the purely combinational state-to-output decode. The state register and next-state logic stay in multicycle_control.

## Test plan
- Reset then release, mem_ready=1 -> S_RST outputs all 0; fetch cycle shows MemRead=1, IRWrite=1, PCWRITE=1.
- lw (100011), mem_ready=1 -> 5 cycles; RegWrite=1 with MemtoReg=1 in cycle 5; back to fetch.
- sw with mem_ready low for 3 cycles in S_MEMWR -> MemWrite held 4 cycles, no RegWrite, 7 cycles total.
- beq (000100) -> cycle 3 shows BRANCH=1, PCSource=01, ALUOp=01, PCWRITE=0; j (000010) -> cycle 3 shows PCWRITE=1, PCSource=10.
- Opcode 111111 -> illegal_op pulse in decode, then fetch; build with and without CTRL_ADDI_EN, where 001000 gives a 4-cycle addi vs an illegal_op pulse.
- rst_n dropped during S_MEMRD -> all outputs 0 at once; after release the FSM restarts at S_FETCH.
